pixel_frame_streamer: RTL

Frame source for the pixel pipeline, i.e. the transmitter that drives the median filter's pixel input.
- On start_i, reads one IMAGE_LEN x IMAGE_HEIGHT frame from an external frame-buffer read port in raster order.
- Drives the pixels on a pixel_valid_if master port and pulses done_o when the last pixel has been emitted.
- Sits between the frame buffer and median_filter.pixel_valid_if_i.

---
 rtl/pixel_frame_streamer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pixel_frame_streamer.sv
// Raster-order frame reader feeding the median filter pixel input; line blanking optional via PIXEL_STREAMER_BLANKING_EN.
// First valid READ_LATENCY+2 cycles after start is accepted; downstream has no backpressure, so reads run back-to-back.

package median_filter_pkg;
   typedef logic [7:0] pixel_t;
endpackage

interface pixel_valid_if;
   import median_filter_pkg::*;
   logic   valid;
   pixel_t pixel;
   modport master (output valid, output pixel);
   modport slave  (input valid, input pixel);
endinterface

module pixel_frame_streamer
   import median_filter_pkg::*;
#(
   parameter int IMAGE_LEN    = 1080,
   parameter int IMAGE_HEIGHT = 720,
   parameter int READ_LATENCY = 1,
`ifdef PIXEL_STREAMER_BLANKING_EN
   parameter int H_BLANK      = 16,
`endif
   localparam int N_PIX  = IMAGE_LEN * IMAGE_HEIGHT,
   localparam int ADDR_W = (N_PIX > 1) ? $clog2(N_PIX) : 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  pixel_t            rd_data_i,
   output logic              busy_o,
   output logic              done_o,
   pixel_valid_if.master     pixel_valid_if_o
);

   localparam int COL_W = (IMAGE_LEN > 1) ? $clog2(IMAGE_LEN) : 1;
   localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_LEN - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
`ifdef PIXEL_STREAMER_BLANKING_EN
      , HBLANK
`endif
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [COL_W-1:0]        col;
   logic [ROW_W-1:0]        row;
   logic [ADDR_W-1:0]       addr;
   logic [READ_LATENCY-1:0] rd_pipe;
   logic [READ_LATENCY-1:0] rd_pipe_nxt;
   logic                    valid_q;
   pixel_t                  pixel_q;
   logic                    line_end;
   logic                    last_rd;

   assign line_end = (col == COL_LAST);
   assign last_rd  = line_end && (row == ROW_LAST);

`ifdef PIXEL_STREAMER_BLANKING_EN
   localparam int BLANK_W = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

   logic [BLANK_W-1:0] blank_cnt;
   logic               blank_end;

   assign blank_end = (blank_cnt == BLANK_W'(H_BLANK - 1));

   always_ff @(posedge clk) begin
      if (rst || state != HBLANK) begin
         blank_cnt <= '0;
      end else begin
         blank_cnt <= blank_cnt + BLANK_W'(1);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rd_en_o   = 1'b0;
      done_o    = 1'b0;
      busy_o    = (state != IDLE);
      case (state)
         IDLE: begin
            if (start_i) state_nxt = READ;
         end
         READ: begin
            rd_en_o = 1'b1;
            if (last_rd) begin
               state_nxt = DRAIN;
            end
`ifdef PIXEL_STREAMER_BLANKING_EN
            else if (line_end && H_BLANK > 0) begin
               state_nxt = HBLANK;
            end
`endif
         end
`ifdef PIXEL_STREAMER_BLANKING_EN
         HBLANK: begin
            if (blank_end) state_nxt = READ;
         end
`endif
         // The output register still holds the final pixel here, so done lands one cycle after it.
         DRAIN: begin
            if (rd_pipe == '0) state_nxt = DONE;
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address advances alongside col/row so no row*IMAGE_LEN product is ever formed.
   always_ff @(posedge clk) begin
      if (rst) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (state == IDLE && start_i) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (state == READ && !last_rd) begin
         addr <= addr + ADDR_W'(1);
         if (line_end) begin
            col <= '0;
            row <= row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   assign rd_addr_o = addr;

   always_comb begin
      rd_pipe_nxt    = rd_pipe << 1;
      rd_pipe_nxt[0] = rd_en_o;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pipe <= '0;
         valid_q <= 1'b0;
         pixel_q <= '0;
      end else begin
         rd_pipe <= rd_pipe_nxt;
         valid_q <= rd_pipe[READ_LATENCY-1];
         if (rd_pipe[READ_LATENCY-1]) pixel_q <= rd_data_i;
      end
   end

   assign pixel_valid_if_o.valid = valid_q;
   assign pixel_valid_if_o.pixel = pixel_q;

endmodule
